// File: rtl/cfg_rx_pkg.sv
// cfg_rx_pkg: shared state encoding and header field layout for the config receiver
package cfg_rx_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HEADER, ST_DATA, ST_WAIT_RELEASE} cfg_rx_state_t;
  localparam int CFG_ADDR_W = 8;
  localparam int HDR_ADDR_LSB = 0;
  localparam int HDR_COUNT_LSB = HDR_ADDR_LSB + CFG_ADDR_W;
  localparam int HDR_COUNT_W = 8;
endpackage

// File: rtl/cfg_word_shifter.sv
// cfg_word_shifter: LSB-first shift register with bit counter; word shows the value after this cycle's shift
module cfg_word_shifter #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              shift,
  input  logic              in,
  output logic [WORD_W-1:0] word,
  output logic              word_complete
);
  localparam int CNT_W = $clog2(WORD_W + 1);
  logic [WORD_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    word_complete = shift && cnt_q == CNT_W'(WORD_W - 1);
    word_d = clear ? '0 : shift ? {in, word_q[WORD_W-1:1]} : word_q;
    cnt_d = (clear || word_complete) ? '0 : shift ? cnt_q + CNT_W'(1) : cnt_q;
  end
  assign word = word_d;
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      cnt_q <= '0;
    end else begin
      word_q <= word_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/serial_config_receiver.sv
// serial_config_receiver: frames a serial header + data burst into single-cycle register writes
module serial_config_receiver
  import cfg_rx_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int ADDR_W = 8,
  parameter int MAX_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  input  logic              bit_strobe,
  input  logic              frame_active,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              frame_done,
  output logic              frame_error
);
  localparam int CNT_LSB = HDR_COUNT_LSB - CFG_ADDR_W + ADDR_W;
  localparam logic [HDR_COUNT_W-1:0] MAX_CNT = HDR_COUNT_W'(MAX_WORDS);
  cfg_rx_state_t state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d, wr_addr_q, wr_addr_d;
  logic [HDR_COUNT_W-1:0] count_q, count_d, idx_q, idx_d, hdr_count;
  logic [WORD_W-1:0] wr_data_q, wr_data_d, word;
  logic wr_en_q, wr_en_d, done_q, done_d, err_q, err_d;
  logic clear, shift, word_complete, hdr_bad;
  // A falling frame_active suppresses the strobe so a coincident final bit never completes a word
  assign clear = state_q == ST_IDLE && frame_active;
  assign shift = bit_strobe && frame_active && (state_q == ST_HEADER || state_q == ST_DATA);
  assign hdr_count = word[CNT_LSB +: HDR_COUNT_W];
  assign hdr_bad = hdr_count == '0 || hdr_count > MAX_CNT;
  cfg_word_shifter #(.WORD_W(WORD_W)) u_shifter (
    .clk          (clk),
    .rst          (rst),
    .clear        (clear),
    .shift        (shift),
    .in           (serial_in),
    .word         (word),
    .word_complete(word_complete)
  );
  always_comb begin
    state_d = state_q;
    base_d = base_q;
    count_d = count_q;
    idx_d = idx_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d = 1'b0;
    done_d = 1'b0;
    err_d = 1'b0;
    case (state_q)
      ST_IDLE: state_d = frame_active ? ST_HEADER : ST_IDLE;
      ST_HEADER: begin
        if (!frame_active) begin
          err_d = 1'b1;
          state_d = ST_IDLE;
        end else if (word_complete) begin
          base_d = word[HDR_ADDR_LSB +: ADDR_W];
          count_d = hdr_count;
          idx_d = '0;
          err_d = hdr_bad;
          state_d = hdr_bad ? ST_WAIT_RELEASE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (!frame_active) begin
          err_d = 1'b1;
          state_d = ST_IDLE;
        end else if (word_complete) begin
          wr_en_d = 1'b1;
          wr_addr_d = base_q + ADDR_W'(idx_q);
          wr_data_d = word;
          idx_d = idx_q + 8'd1;
          done_d = idx_q + 8'd1 == count_q;
          state_d = done_d ? ST_WAIT_RELEASE : ST_DATA;
        end
      end
      ST_WAIT_RELEASE: state_d = frame_active ? ST_WAIT_RELEASE : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q <= '0;
      count_q <= '0;
      idx_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q <= base_d;
      count_q <= count_d;
      idx_q <= idx_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q <= wr_en_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign frame_done = done_q;
  assign frame_error = err_q;
  assign busy = state_q == ST_HEADER || state_q == ST_DATA;
endmodule
